memory1_stage: RTL and testbench
================================

Name: memory1_stage

Overview:
First memory pipeline stage, between execute and memory2. Registers the execute payload and checks load/store alignment. Issues exactly one dcache request per memory instruction, using a valid/ready handshake. Produces the byte-lane metadata memory2 needs to extract load data, and drives the operand-forwarding request for non-load results.

Parameters:
- ADDR_W, 32, virtual/physical address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- is_stall  in  1  pipeline hold from ctrl; input register keeps its value
- is_flush  in  1  pipeline flush from ctrl
- pass_in  in  execute_memory1_pass_t  payload from execute
- pass_out  out  memory1_memory2_pass_t  payload to memory2
- fwd_req  out  forward_req_t  {valid, idx, data} forwarding source
- load_pending  out  1  load in this stage; hazard unit uses it for load-use stall
- load_rd  out  5  destination of that load
- dcache_req_valid  out  1  request valid
- dcache_req_ready  in  1  dcache accepts this cycle
- dcache_req_we  out  1  1 = store
- dcache_req_addr  out  ADDR_W  address (pass_in_r.ex_out)
- dcache_req_wstrb  out  DATA_W/8  store byte strobes
- dcache_req_wdata  out  DATA_W  lane-replicated store data
- dcache_req_stall  out  1  to ctrl: request offered, not accepted

Behaviour:
- **Input register:** async reset sets is_flush=1 and all other fields 0. Loads pass_in when ~is_stall; holds otherwise.
- **Flush:** mem1_flush = is_flush | pass_in_r.is_flush.
- **Alignment:**
  - WORD needs addr[1:0]==0; HALF_WORD needs addr[0]==0; BYTE is always aligned.
  - misaligned = is_mem & ~aligned.
  - When misaligned: no dcache request; pass_out.exc_valid=1, pass_out.ecode=ALE, pass_out.badv=addr.
- **Strobes:**
  - BYTE: 4'b0001<<addr[1:0], wdata = {4{st_data[7:0]}}.
  - HALF: 4'b0011<<{addr[1],1'b0}, wdata = {2{st_data[15:0]}}.
  - WORD: 4'b1111, wdata = st_data.
  - Loads drive wstrb=0.
- **Request FSM (2 states):**
  - IDLE: dcache_req_valid = is_mem & ~mem1_flush & ~misaligned.
  - IDLE, valid & ready & is_stall -> SENT. IDLE, valid & ready & ~is_stall -> stay IDLE (next instruction loads).
  - SENT: dcache_req_valid=0. SENT -> IDLE when ~is_stall or is_flush.
  - Reset -> IDLE.
  - A store is never issued twice, whatever the downstream stall length.
- **Handshake:**
  - addr/we/wstrb/wdata stay stable while valid & ~ready.
  - A flush drops valid combinationally in the same cycle; dcache must tolerate a withdrawn request.
  - dcache_req_stall = dcache_req_valid & ~dcache_req_ready, valid in the same cycle.
- **Outputs to memory2:**
  - pass_out.is_flush = mem1_flush | dcache_req_stall.
  - byte_en = addr[1:0].
  - Pass through: byte_type, is_signed, is_mem, ex_out, pc, inst, rd, is_wr_rd, is_wr_rd_pc_plus4, pc_plus4, is_wr_csr, csr_addr.
  - An exception instruction is not flushed; it carries exc to writeback.
- **Forwarding:**
  - fwd_req.valid = is_wr_rd & ~is_mem & ~mem1_flush.
  - fwd_req.idx = rd.
  - fwd_req.data = pc_plus4 if is_wr_rd_pc_plus4, else ex_out.
- **Load-use:** load_pending = is_mem & ~we & is_wr_rd & ~mem1_flush; load_rd = rd.
- **Simultaneous events:** flush and ready in the same cycle -> valid already 0, no transfer. Reset mid-handshake -> IDLE, valid=0 immediately.

Decomposition:
- Shared cpu_defs package holds:
  - execute_memory1_pass_t, memory1_memory2_pass_t, forward_req_t
  - byte_type_t {BYTE, HALF_WORD, WORD}
  - ecode ALE
  - dcache_req_t bundle
- One natural sub-module: store_align (pure combinational: byte_type, addr[1:0], st_data -> wstrb, wdata, aligned).

Test Plan:
- Load word, addr 0x1000, ready=1, no stall -> valid=1 one cycle, we=0, wstrb=0000; pass_out.byte_en=00, is_flush=0.
- Store byte, addr 0x1003, st_data=0x000000AB -> wstrb=1000, wdata=0xABABABAB, we=1.
- Store half, addr 0x2002, ready low 3 cycles -> valid held 3 cycles, addr stable, dcache_req_stall=1, pass_out.is_flush=1; then one transfer.
- Store accepted while is_stall=1 for 4 cycles -> exactly one valid&ready, FSM in SENT until stall releases.
- Load word, addr 0x1002 -> no request, exc_valid=1, ecode=ALE, badv=0x1002.
- Flush asserted while valid & ~ready -> valid=0 same cycle, no transfer. Then ALU op rd=5 with ex_out=0x55 -> fwd_req={1,5,0x55}, load_pending=0.

Source files
------------

// File: rtl/memory1_stage_pkg.sv
// Shared types for the memory1 stage: pipeline payloads, forwarding request, dcache bundle.
package memory1_stage_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = DataW / 8;

    // Address-misaligned exception code
    localparam logic [5:0] ALE = 6'h09;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_t;

    typedef enum logic {
        StIdle,
        StSent
    } req_state_e;

    typedef struct packed {
        logic        is_flush;
        logic        is_mem;
        logic        we;
        byte_type_t  byte_type;
        logic        is_signed;
        logic [31:0] ex_out;
        logic [31:0] st_data;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic        is_wr_csr;
        logic [13:0] csr_addr;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        is_flush;
        byte_type_t  byte_type;
        logic        is_signed;
        logic        is_mem;
        logic [1:0]  byte_en;
        logic [31:0] ex_out;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic        is_wr_csr;
        logic [13:0] csr_addr;
        logic        exc_valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } forward_req_t;

    typedef struct packed {
        logic             valid;
        logic             we;
        logic [AddrW-1:0] addr;
        logic [StrbW-1:0] wstrb;
        logic [DataW-1:0] wdata;
    } dcache_req_t;

endpackage

// File: rtl/memory1_stage_if.sv
// Dcache request channel: valid/ready handshake carrying address, strobes and store data.
interface memory1_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;

    modport master (output valid, output we, output addr, output wstrb, output wdata, input ready);
    modport slave  (input valid, input we, input addr, input wstrb, input wdata, output ready);
endinterface

// File: rtl/memory1_stage_store_align.sv
// Byte-lane alignment for dcache stores: strobes, lane-replicated data and alignment check.
module memory1_stage_store_align
    import memory1_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  byte_type_t            byte_type_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_W-1:0]     st_data_i,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  aligned_o
);
    localparam int unsigned SW = DATA_W / 8;

    always_comb begin
        wstrb_o   = '0;
        wdata_o   = st_data_i;
        aligned_o = 1'b1;
        case (byte_type_i)
            BYTE: begin
                wstrb_o = SW'(1) << addr_lo_i;
                wdata_o = {(DATA_W / 8){st_data_i[7:0]}};
            end
            HALF_WORD: begin
                wstrb_o   = SW'(3) << {addr_lo_i[1], 1'b0};
                wdata_o   = {(DATA_W / 16){st_data_i[15:0]}};
                aligned_o = ~addr_lo_i[0];
            end
            WORD: begin
                wstrb_o   = '1;
                aligned_o = (addr_lo_i == 2'b00);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/memory1_stage.sv
// First memory pipeline stage: registers the execute payload, issues one dcache request per
// memory instruction, flags misaligned accesses and drives forwarding / load-use signals.
module memory1_stage
    import memory1_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_stall_i,
    input  logic                  is_flush_i,
    input  execute_memory1_pass_t pass_in_i,
    output memory1_memory2_pass_t pass_out_o,
    output forward_req_t          fwd_req_o,
    output logic                  load_pending_o,
    output logic [4:0]            load_rd_o,
    memory1_stage_if.master       dcache_io,
    output logic                  dcache_req_stall_o
);
    execute_memory1_pass_t pass_q;
    req_state_e            state_q, state_d;
    logic                  mem1_flush, aligned, misaligned, req_valid;
    logic [DATA_W/8-1:0]   strb;
    logic [DATA_W-1:0]     wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q          <= '0;
            pass_q.is_flush <= 1'b1;
        end else if (!is_stall_i) begin
            pass_q <= pass_in_i;
        end
    end

    memory1_stage_store_align #(
        .DATA_W(DATA_W)
    ) u_store_align (
        .byte_type_i(pass_q.byte_type),
        .addr_lo_i  (pass_q.ex_out[1:0]),
        .st_data_i  (pass_q.st_data[DATA_W-1:0]),
        .wstrb_o    (strb),
        .wdata_o    (wdata),
        .aligned_o  (aligned)
    );

    assign mem1_flush = is_flush_i | pass_q.is_flush;
    assign misaligned = pass_q.is_mem & ~aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // SENT remembers that the held instruction was already accepted, so a long stall
    // never re-issues it.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_valid = pass_q.is_mem & ~mem1_flush & ~misaligned;
                if (req_valid & dcache_io.ready & is_stall_i) state_d = StSent;
            end
            StSent: begin
                if (~is_stall_i | is_flush_i) state_d = StIdle;
            end
        endcase
    end

    assign dcache_io.valid  = req_valid;
    assign dcache_io.we     = pass_q.we;
    assign dcache_io.addr   = pass_q.ex_out[ADDR_W-1:0];
    assign dcache_io.wstrb  = pass_q.we ? strb : '0;
    assign dcache_io.wdata  = wdata;
    assign dcache_req_stall_o = req_valid & ~dcache_io.ready;

    always_comb begin
        pass_out_o                   = '0;
        pass_out_o.is_flush          = mem1_flush | dcache_req_stall_o;
        pass_out_o.byte_type         = pass_q.byte_type;
        pass_out_o.is_signed         = pass_q.is_signed;
        pass_out_o.is_mem            = pass_q.is_mem;
        pass_out_o.byte_en           = pass_q.ex_out[1:0];
        pass_out_o.ex_out            = pass_q.ex_out;
        pass_out_o.pc                = pass_q.pc;
        pass_out_o.inst              = pass_q.inst;
        pass_out_o.rd                = pass_q.rd;
        pass_out_o.is_wr_rd          = pass_q.is_wr_rd;
        pass_out_o.is_wr_rd_pc_plus4 = pass_q.is_wr_rd_pc_plus4;
        pass_out_o.pc_plus4          = pass_q.pc_plus4;
        pass_out_o.is_wr_csr         = pass_q.is_wr_csr;
        pass_out_o.csr_addr          = pass_q.csr_addr;
        pass_out_o.exc_valid         = misaligned;
        pass_out_o.ecode             = misaligned ? ALE : 6'd0;
        pass_out_o.badv              = misaligned ? pass_q.ex_out : 32'd0;
    end

    always_comb begin
        fwd_req_o.valid = pass_q.is_wr_rd & ~pass_q.is_mem & ~mem1_flush;
        fwd_req_o.idx   = pass_q.rd;
        fwd_req_o.data  = pass_q.is_wr_rd_pc_plus4 ? pass_q.pc_plus4 : pass_q.ex_out;
    end

    assign load_pending_o = pass_q.is_mem & ~pass_q.we & pass_q.is_wr_rd & ~mem1_flush;
    assign load_rd_o      = pass_q.rd;
endmodule

// File: tb/tb_memory1_stage.sv
// Self-checking bench for memory1_stage: directed scenarios then randomized traffic against a
// transaction-level model of the stage.
module tb_memory1_stage;
    import memory1_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  is_stall, is_flush;
    execute_memory1_pass_t pass_in;
    memory1_memory2_pass_t pass_out;
    forward_req_t          fwd_req;
    logic                  load_pending, req_stall;
    logic [4:0]            load_rd;

    memory1_stage_if #(.ADDR_W(32), .DATA_W(32)) dc_if ();

    memory1_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .is_stall_i        (is_stall),
        .is_flush_i        (is_flush),
        .pass_in_i         (pass_in),
        .pass_out_o        (pass_out),
        .fwd_req_o         (fwd_req),
        .load_pending_o    (load_pending),
        .load_rd_o         (load_rd),
        .dcache_io         (dc_if.master),
        .dcache_req_stall_o(req_stall)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_dut_xfer = 0;
    int x0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: the instruction held in the stage and whether it was already accepted by dcache.
    execute_memory1_pass_t m_reg;
    bit                    m_issued;
    bit                    m_valid;
    bit                    dut_xfer;

    task automatic model_reset();
        m_reg          = '0;
        m_reg.is_flush = 1'b1;
        m_issued       = 1'b0;
    endtask

    function automatic execute_memory1_pass_t mk(input bit mem, input bit we, input byte_type_t bt,
                                                 input logic [31:0] addr, input logic [31:0] st,
                                                 input logic [4:0] rd, input bit wr);
        execute_memory1_pass_t p;
        p           = '0;
        p.is_mem    = mem;
        p.we        = we;
        p.byte_type = bt;
        p.ex_out    = addr;
        p.st_data   = st;
        p.rd        = rd;
        p.is_wr_rd  = wr;
        p.pc        = 32'h1c00_0000 + {addr[15:0], 2'b00};
        p.inst      = 32'h0280_0000 ^ addr;
        p.pc_plus4  = p.pc + 32'd4;
        return p;
    endfunction

    task automatic drive(input execute_memory1_pass_t p, input bit stall, input bit flush,
                         input bit rdy);
        @(negedge clk);
        pass_in     = p;
        is_stall    = stall;
        is_flush    = flush;
        dc_if.ready = rdy;
        #2;
    endtask

    task automatic model_check();
        int unsigned       sz, off;
        logic [31:0]       a;
        logic [3:0]        estrb;
        logic [31:0]       ewd, efwd;
        bit                fl, mis;
        a   = m_reg.ex_out;
        sz  = (m_reg.byte_type == BYTE) ? 1 : (m_reg.byte_type == HALF_WORD) ? 2 : 4;
        off = ((a % 4) / sz) * sz;
        fl  = is_flush || m_reg.is_flush;
        mis = m_reg.is_mem && ((a % sz) != 0);
        for (int k = 0; k < 4; k++) begin
            estrb[k]       = m_reg.we && (k >= off) && (k < off + sz);
            ewd[8*k +: 8]  = m_reg.st_data[8*(k % sz) +: 8];
        end
        m_valid  = !m_issued && m_reg.is_mem && !fl && !mis;
        dut_xfer = dc_if.valid && dc_if.ready;
        efwd     = m_reg.is_wr_rd_pc_plus4 ? m_reg.pc_plus4 : m_reg.ex_out;

        check_eq("req_valid", 32'(dc_if.valid), 32'(m_valid));
        check_eq("req_we", 32'(dc_if.we), 32'(m_reg.we));
        check_eq("req_wstrb", 32'(dc_if.wstrb), 32'(estrb));
        if (m_valid) begin
            check_eq("req_addr", dc_if.addr, a);
            check_eq("req_wdata", dc_if.wdata, ewd);
        end
        check_eq("req_stall", 32'(req_stall), 32'(m_valid && !dc_if.ready));
        check_eq("out_flush", 32'(pass_out.is_flush), 32'(fl || (m_valid && !dc_if.ready)));
        check_eq("out_byte_en", 32'(pass_out.byte_en), a % 4);
        check_eq("out_exc", 32'(pass_out.exc_valid), 32'(mis));
        check_eq("out_ecode", 32'(pass_out.ecode), mis ? 32'(ALE) : 32'd0);
        check_eq("out_badv", pass_out.badv, mis ? a : 32'd0);
        check_eq("out_ex_out", pass_out.ex_out, a);
        check_eq("out_pc", pass_out.pc, m_reg.pc);
        check_eq("out_inst", pass_out.inst, m_reg.inst);
        check_eq("out_pc4", pass_out.pc_plus4, m_reg.pc_plus4);
        check_eq("out_rd", 32'(pass_out.rd), 32'(m_reg.rd));
        check_eq("out_flags",
                 32'({pass_out.byte_type, pass_out.is_signed, pass_out.is_mem, pass_out.is_wr_rd,
                      pass_out.is_wr_rd_pc_plus4, pass_out.is_wr_csr, pass_out.csr_addr}),
                 32'({m_reg.byte_type, m_reg.is_signed, m_reg.is_mem, m_reg.is_wr_rd,
                      m_reg.is_wr_rd_pc_plus4, m_reg.is_wr_csr, m_reg.csr_addr}));
        check_eq("fwd_valid", 32'(fwd_req.valid), 32'(m_reg.is_wr_rd && !m_reg.is_mem && !fl));
        check_eq("fwd_idx", 32'(fwd_req.idx), 32'(m_reg.rd));
        check_eq("fwd_data", fwd_req.data, efwd);
        check_eq("load_pending", 32'(load_pending),
                 32'(m_reg.is_mem && !m_reg.we && m_reg.is_wr_rd && !fl));
        check_eq("load_rd", 32'(load_rd), 32'(m_reg.rd));
    endtask

    task automatic advance();
        @(posedge clk);
        if (dut_xfer) n_dut_xfer++;
        if (rst_n) begin
            if (!is_stall) begin
                m_reg    = pass_in;
                m_issued = 1'b0;
            end else if (is_flush) begin
                m_issued = 1'b0;
            end else if (m_valid && dc_if.ready) begin
                m_issued = 1'b1;
            end
        end
    endtask

    task automatic cyc(input execute_memory1_pass_t p, input bit stall, input bit flush,
                       input bit rdy);
        drive(p, stall, flush, rdy);
        model_check();
        advance();
    endtask

    execute_memory1_pass_t bubble, p;

    initial begin
        bubble = '0;
        model_reset();
        // Reset state
        drive(bubble, 1'b0, 1'b0, 1'b1);
        model_check();
        check_eq("rst_out_flush", 32'(pass_out.is_flush), 32'd1);
        advance();
        drive(mk(1, 0, WORD, 32'h1000, 0, 5'd7, 1), 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        model_check();
        advance();

        // Load word, aligned
        drive(bubble, 1'b0, 1'b0, 1'b1);
        model_check();
        check_eq("lw_valid", 32'(dc_if.valid), 32'd1);
        check_eq("lw_wstrb", 32'(dc_if.wstrb), 32'd0);
        check_eq("lw_pflush", 32'(pass_out.is_flush), 32'd0);
        check_eq("lw_pending", 32'(load_pending), 32'd1);
        advance();

        // Store byte to lane 3
        cyc(mk(1, 1, BYTE, 32'h1003, 32'h0000_00AB, 5'd0, 0), 1'b0, 1'b0, 1'b1);
        drive(bubble, 1'b0, 1'b0, 1'b1);
        model_check();
        check_eq("sb_wstrb", 32'(dc_if.wstrb), 32'h8);
        check_eq("sb_wdata", dc_if.wdata, 32'hABAB_ABAB);
        advance();

        // Store half with ready held low for three cycles
        cyc(mk(1, 1, HALF_WORD, 32'h2002, 32'h0000_BEEF, 5'd0, 0), 1'b0, 1'b0, 1'b0);
        x0 = n_dut_xfer;
        for (int i = 0; i < 3; i++) begin
            drive(bubble, 1'b1, 1'b0, 1'b0);
            model_check();
            check_eq("sh_hold_addr", dc_if.addr, 32'h2002);
            check_eq("sh_hold_stall", 32'(req_stall), 32'd1);
            advance();
        end
        cyc(bubble, 1'b0, 1'b0, 1'b1);
        check_eq("sh_one_xfer", 32'(n_dut_xfer - x0), 32'd1);

        // Store accepted under a four-cycle downstream stall
        cyc(mk(1, 1, WORD, 32'h3000, 32'h1234_5678, 5'd0, 0), 1'b0, 1'b0, 1'b1);
        x0 = n_dut_xfer;
        for (int i = 0; i < 4; i++) cyc(bubble, 1'b1, 1'b0, 1'b1);
        cyc(bubble, 1'b0, 1'b0, 1'b1);
        check_eq("sw_stall_one_xfer", 32'(n_dut_xfer - x0), 32'd1);

        // Misaligned load word
        cyc(mk(1, 0, WORD, 32'h1002, 0, 5'd3, 1), 1'b0, 1'b0, 1'b1);
        drive(bubble, 1'b0, 1'b0, 1'b1);
        model_check();
        check_eq("ale_exc", 32'(pass_out.exc_valid), 32'd1);
        check_eq("ale_badv", pass_out.badv, 32'h1002);
        advance();

        // Flush while request is waiting, then an ALU result to forward
        cyc(mk(1, 1, WORD, 32'h4000, 32'hCAFE_F00D, 5'd0, 0), 1'b0, 1'b0, 1'b0);
        x0 = n_dut_xfer;
        cyc(bubble, 1'b1, 1'b0, 1'b0);
        drive(bubble, 1'b1, 1'b1, 1'b1);
        model_check();
        check_eq("flush_valid", 32'(dc_if.valid), 32'd0);
        advance();
        check_eq("flush_no_xfer", 32'(n_dut_xfer - x0), 32'd0);
        cyc(mk(0, 0, WORD, 32'h55, 0, 5'd5, 1), 1'b0, 1'b0, 1'b1);
        drive(bubble, 1'b0, 1'b0, 1'b1);
        model_check();
        check_eq("alu_fwd", 32'({fwd_req.valid, fwd_req.idx}), 32'({1'b1, 5'd5}));
        check_eq("alu_fwd_data", fwd_req.data, 32'h55);
        advance();

        // Reset in the middle of a handshake
        cyc(mk(1, 1, WORD, 32'h5000, 32'h1, 5'd0, 0), 1'b0, 1'b0, 1'b0);
        drive(bubble, 1'b1, 1'b0, 1'b0);
        model_check();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(dc_if.valid), 32'd0);
        model_reset();
        advance();
        drive(bubble, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        model_check();
        advance();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            p                   = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                                     byte_type_t'($urandom_range(0, 2)), $urandom, $urandom,
                                     5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
            p.is_flush          = $urandom_range(0, 9) == 0;
            p.is_signed         = $urandom_range(0, 1) == 1;
            p.is_wr_rd_pc_plus4 = $urandom_range(0, 3) == 0;
            p.is_wr_csr         = $urandom_range(0, 7) == 0;
            p.csr_addr          = 14'($urandom);
            cyc(p, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
